// File: rtl/ahb3lite_sram_slave_if.sv
// rtl/ahb3lite_sram_slave_if.sv - AHB3-Lite bus bundle with master and slave views.
interface ahb3lite_sram_slave_if #(
    parameter int HADDR_SIZE = 32,
    parameter int HDATA_SIZE = 32
);
    logic                  HSEL;
    logic [HADDR_SIZE-1:0] HADDR;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [2:0]            HBURST;
    logic [3:0]            HPROT;
    logic [1:0]            HTRANS;
    logic [HDATA_SIZE-1:0] HWDATA;
    logic                  HREADY;
    logic                  HREADYOUT;
    logic                  HRESP;
    logic [HDATA_SIZE-1:0] HRDATA;

    modport master (
        output HSEL, HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HWDATA, HREADY,
        input  HREADYOUT, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HWDATA, HREADY,
        output HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/ahb3lite_sram_slave.sv
// rtl/ahb3lite_sram_slave.sv - AHB3-Lite SRAM slave with wait states and two-cycle ERROR.
module ahb3lite_sram_slave #(
    parameter int HADDR_SIZE  = 32,
    parameter int HDATA_SIZE  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    ahb3lite_sram_slave_if.slave bus
);
    localparam int                  IDX_W     = $clog2(MEM_DEPTH);
    localparam int                  ADDR_W    = IDX_W + 2;
    localparam logic [HADDR_SIZE:0] MEM_BYTES = (HADDR_SIZE + 1)'(MEM_DEPTH) << 2;
    localparam logic [2:0]          WAIT_INIT = 3'(WAIT_STATES);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_LAST, S_ERR1, S_ERR2} state_t;

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              write_q, write_d;
    logic [2:0]        size_q, size_d;

    logic [HDATA_SIZE-1:0] mem [MEM_DEPTH];
    logic                  xfer_req;
    logic                  illegal;
    logic                  mem_we;
    logic [3:0]            byte_en;
    logic [IDX_W-1:0]      word_idx;
    logic                  unused_bits;

    assign unused_bits = ^{bus.HBURST, bus.HPROT, bus.HTRANS[0]};
    assign xfer_req    = bus.HSEL & bus.HREADY & bus.HTRANS[1];
    assign word_idx    = addr_q[ADDR_W-1:2];

    always_comb begin
        illegal = 1'b0;
        case (bus.HSIZE)
            3'b000:  illegal = 1'b0;
            3'b001:  illegal = bus.HADDR[0];
            3'b010:  illegal = |bus.HADDR[1:0];
            default: illegal = 1'b1;
        endcase
        if ({1'b0, bus.HADDR} >= MEM_BYTES) begin
            illegal = 1'b1;
        end
    end

    // Only IDLE, LAST and ERR2 drive HREADYOUT high, so only they can take a new address phase.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        size_d  = size_q;
        case (state_q)
            S_WAIT: begin
                if (cnt_q <= 3'd1) begin
                    cnt_d   = 3'd0;
                    state_d = S_LAST;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_ERR1: state_d = S_ERR2;
            default: begin
                if (xfer_req) begin
                    addr_d  = bus.HADDR[ADDR_W-1:0];
                    write_d = bus.HWRITE;
                    size_d  = bus.HSIZE;
                    if (illegal) begin
                        state_d = S_ERR1;
                    end else if (WAIT_INIT != 3'd0) begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_INIT;
                    end else begin
                        state_d = S_LAST;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            size_q  <= size_d;
        end
    end

    always_comb begin
        byte_en = 4'b0000;
        case (size_q)
            3'b000:  byte_en = 4'b0001 << addr_q[1:0];
            3'b001:  byte_en = addr_q[1] ? 4'b1100 : 4'b0011;
            3'b010:  byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase
    end

    // Reset forces state_q to IDLE asynchronously, so an aborted transfer never reaches this write.
    assign mem_we = (state_q == S_LAST) && write_q;

    always_ff @(posedge HCLK) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[word_idx][b*8 +: 8] <= bus.HWDATA[b*8 +: 8];
                end
            end
        end
    end

    assign bus.HREADYOUT = !((state_q == S_WAIT) || (state_q == S_ERR1));
    assign bus.HRESP     = (state_q == S_ERR1) || (state_q == S_ERR2);
    assign bus.HRDATA    = ((state_q == S_LAST) && !write_q) ? mem[word_idx] : '0;
endmodule

// File: tb/tb_ahb3lite_sram_slave.sv
// tb/tb_ahb3lite_sram_slave.sv - scoreboard bench for the AHB3-Lite SRAM slave.
module tb_ahb3lite_sram_slave;
    logic clk = 1'b0;
    logic rst0, rst2;
    logic sel2;

    logic        t_hsel;
    logic [31:0] t_haddr;
    logic        t_hwrite;
    logic [2:0]  t_hsize;
    logic [1:0]  t_htrans;
    logic [31:0] t_hwdata;

    logic        obs_ready, obs_resp;
    logic [31:0] obs_rdata;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       tag;
        bit          hsel;
        logic [1:0]  htrans;
        bit          write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        bit          err;
    } op_t;

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        bit          err;
        int          waits;
    } exp_t;

    op_t  ops[$];
    exp_t sb[$];

    always #5 clk = ~clk;

    ahb3lite_sram_slave_if #(.HADDR_SIZE(32), .HDATA_SIZE(32)) bif0 ();
    ahb3lite_sram_slave_if #(.HADDR_SIZE(32), .HDATA_SIZE(32)) bif2 ();

    assign bif0.HSEL   = t_hsel & ~sel2;
    assign bif2.HSEL   = t_hsel & sel2;
    assign bif0.HADDR  = t_haddr;
    assign bif2.HADDR  = t_haddr;
    assign bif0.HWRITE = t_hwrite;
    assign bif2.HWRITE = t_hwrite;
    assign bif0.HSIZE  = t_hsize;
    assign bif2.HSIZE  = t_hsize;
    assign bif0.HBURST = 3'b000;
    assign bif2.HBURST = 3'b000;
    assign bif0.HPROT  = 4'b0011;
    assign bif2.HPROT  = 4'b0011;
    assign bif0.HTRANS = t_htrans;
    assign bif2.HTRANS = t_htrans;
    assign bif0.HWDATA = t_hwdata;
    assign bif2.HWDATA = t_hwdata;
    assign bif0.HREADY = bif0.HREADYOUT;
    assign bif2.HREADY = bif2.HREADYOUT;

    assign obs_ready = sel2 ? bif2.HREADYOUT : bif0.HREADYOUT;
    assign obs_resp  = sel2 ? bif2.HRESP     : bif0.HRESP;
    assign obs_rdata = sel2 ? bif2.HRDATA    : bif0.HRDATA;

    ahb3lite_sram_slave #(.HADDR_SIZE(32), .HDATA_SIZE(32), .MEM_DEPTH(256), .WAIT_STATES(0)) dut0 (
        .HCLK(clk), .HRESET(rst0), .bus(bif0)
    );
    ahb3lite_sram_slave #(.HADDR_SIZE(32), .HDATA_SIZE(32), .MEM_DEPTH(256), .WAIT_STATES(2)) dut2 (
        .HCLK(clk), .HRESET(rst2), .bus(bif2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic add_op(input string tag, input bit hsel, input logic [1:0] htrans, input bit wr,
                          input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input bit err);
        op_t o;
        o.tag = tag; o.hsel = hsel; o.htrans = htrans; o.write = wr; o.size = size;
        o.addr = addr; o.wdata = wdata; o.rdata = rdata; o.err = err;
        ops.push_back(o);
    endtask

    task automatic drive_idle();
        t_hsel = 1'b0; t_htrans = 2'b00; t_haddr = '0; t_hwrite = 1'b0; t_hsize = 3'b010;
    endtask

    // Pipelined driver: presents address phases back to back, checks each data phase on completion.
    task automatic run_ops(input int max_cycles);
        op_t         a;
        exp_t        e;
        bit          a_valid = 1'b0;
        bit          dp_valid = 1'b0;
        bit          rdy;
        bit          wresp = 1'b0;
        int          waits = 0;
        int          cyc = 0;
        logic [31:0] nxt_wdata = t_hwdata;
        forever begin
            if (!a_valid && ops.size() > 0) begin
                a = ops.pop_front();
                a_valid = 1'b1;
            end
            if (!a_valid && !dp_valid) break;
            if (a_valid) begin
                t_hsel = a.hsel; t_htrans = a.htrans; t_haddr = a.addr;
                t_hwrite = a.write; t_hsize = a.size;
            end else begin
                drive_idle();
            end
            @(negedge clk);
            rdy = obs_ready;
            if (dp_valid) begin
                if (!rdy) begin
                    waits++;
                    wresp = wresp | obs_resp;
                end else if (sb.size() == 0) begin
                    chk("scoreboard_empty", 32'(sb.size()), 32'd1);
                    dp_valid = 1'b0;
                end else begin
                    e = sb.pop_front();
                    chk({e.tag, "_hresp"}, {31'd0, obs_resp}, {31'd0, e.err});
                    chk({e.tag, "_hrdata"}, obs_rdata, e.rdata);
                    chk({e.tag, "_waits"}, 32'(waits), 32'(e.waits));
                    chk({e.tag, "_wait_resp"}, {31'd0, wresp}, {31'd0, e.err});
                    dp_valid = 1'b0;
                end
            end
            if (rdy && a_valid) begin
                if (a.hsel && a.htrans[1]) begin
                    e.tag = a.tag;
                    e.err = a.err;
                    e.rdata = (a.write || a.err) ? 32'h0 : a.rdata;
                    e.waits = a.err ? 1 : (sel2 ? 2 : 0);
                    sb.push_back(e);
                    dp_valid = 1'b1;
                    waits = 0;
                    wresp = 1'b0;
                end
                nxt_wdata = a.wdata;
                a_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            t_hwdata = nxt_wdata;
            cyc++;
            if (cyc > max_cycles) begin
                checks++;
                errors++;
                $error("FAIL run_ops_timeout: observed=%0d cycles expected<=%0d", cyc, max_cycles);
                ops.delete();
                sb.delete();
                break;
            end
        end
        drive_idle();
    endtask

    initial begin
        rst0 = 1'b1; rst2 = 1'b1; sel2 = 1'b0; t_hwdata = '0;
        drive_idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst0_hreadyout", {31'd0, bif0.HREADYOUT}, 32'd1);
        chk("rst0_hresp", {31'd0, bif0.HRESP}, 32'd0);
        chk("rst0_hrdata", bif0.HRDATA, 32'h0);
        chk("rst2_hreadyout", {31'd0, bif2.HREADYOUT}, 32'd1);
        chk("rst2_hresp", {31'd0, bif2.HRESP}, 32'd0);
        chk("rst2_hrdata", bif2.HRDATA, 32'h0);
        @(posedge clk); #1;
        rst0 = 1'b0; rst2 = 1'b0;
        @(posedge clk); #1;

        // Zero-wait slave: pipelined word, byte and halfword traffic plus illegal transfers.
        add_op("w0_cafe", 1, 2'b10, 1, 3'b010, 32'h0, 32'hCAFE_BABE, 32'h0, 0);
        add_op("r0_cafe", 1, 2'b10, 0, 3'b010, 32'h0, 32'h0, 32'hCAFE_BABE, 0);
        add_op("w4_dead", 1, 2'b10, 1, 3'b010, 32'h4, 32'hDEAD_BEEF, 32'h0, 0);
        add_op("r4_dead", 1, 2'b10, 0, 3'b010, 32'h4, 32'h0, 32'hDEAD_BEEF, 0);
        add_op("r0_still", 1, 2'b10, 0, 3'b010, 32'h0, 32'h0, 32'hCAFE_BABE, 0);
        add_op("wb1_aa", 1, 2'b10, 1, 3'b000, 32'h1, 32'h0000_AA00, 32'h0, 0);
        add_op("r0_byte", 1, 2'b10, 0, 3'b010, 32'h0, 32'h0, 32'hCAFE_AABE, 0);
        add_op("wh6_1234", 1, 2'b10, 1, 3'b001, 32'h6, 32'h1234_0000, 32'h0, 0);
        add_op("r4_half", 1, 2'b10, 0, 3'b010, 32'h4, 32'h0, 32'h1234_BEEF, 0);
        add_op("rh6_full", 1, 2'b10, 0, 3'b001, 32'h6, 32'h0, 32'h1234_BEEF, 0);
        add_op("rb3_full", 1, 2'b10, 0, 3'b000, 32'h3, 32'h0, 32'hCAFE_AABE, 0);
        add_op("err_w2", 1, 2'b10, 1, 3'b010, 32'h2, 32'hFFFF_FFFF, 32'h0, 1);
        add_op("r0_after_err", 1, 2'b10, 0, 3'b010, 32'h0, 32'h0, 32'hCAFE_AABE, 0);
        add_op("err_oor", 1, 2'b10, 1, 3'b010, 32'h400, 32'hFFFF_FFFF, 32'h0, 1);
        add_op("err_h3", 1, 2'b10, 1, 3'b001, 32'h3, 32'hFFFF_FFFF, 32'h0, 1);
        add_op("err_size", 1, 2'b11, 1, 3'b011, 32'h0, 32'hFFFF_FFFF, 32'h0, 1);
        add_op("r0_after_errs", 1, 2'b10, 0, 3'b010, 32'h0, 32'h0, 32'hCAFE_AABE, 0);
        add_op("busy_w0", 1, 2'b01, 1, 3'b010, 32'h0, 32'h1111_1111, 32'h0, 0);
        add_op("unsel_w0", 0, 2'b10, 1, 3'b010, 32'h0, 32'h2222_2222, 32'h0, 0);
        add_op("r0_no_access", 1, 2'b10, 0, 3'b010, 32'h0, 32'h0, 32'hCAFE_AABE, 0);
        add_op("w_top", 1, 2'b10, 1, 3'b010, 32'h3FC, 32'h0BAD_F00D, 32'h0, 0);
        add_op("r_top", 1, 2'b10, 0, 3'b010, 32'h3FC, 32'h0, 32'h0BAD_F00D, 0);
        add_op("r4_final", 1, 2'b10, 0, 3'b010, 32'h4, 32'h0, 32'h1234_BEEF, 0);
        run_ops(200);
        @(negedge clk);
        chk("ws0_idle_hreadyout", {31'd0, obs_ready}, 32'd1);
        chk("ws0_idle_hresp", {31'd0, obs_resp}, 32'd0);
        @(posedge clk); #1;

        // Two-wait-state slave.
        sel2 = 1'b1;
        add_op("ws2_w8", 1, 2'b10, 1, 3'b010, 32'h8, 32'h5555_AAAA, 32'h0, 0);
        add_op("ws2_r8", 1, 2'b10, 0, 3'b010, 32'h8, 32'h0, 32'h5555_AAAA, 0);
        add_op("ws2_err_w9", 1, 2'b10, 1, 3'b010, 32'h9, 32'hFFFF_FFFF, 32'h0, 1);
        add_op("ws2_r8_again", 1, 2'b10, 0, 3'b010, 32'h8, 32'h0, 32'h5555_AAAA, 0);
        run_ops(200);

        // Reset in the WAIT state of a write must abort it.
        t_hsel = 1'b1; t_htrans = 2'b10; t_haddr = 32'h8; t_hwrite = 1'b1; t_hsize = 3'b010;
        @(posedge clk); #1;
        t_hwdata = 32'h0BAD_0BAD;
        drive_idle();
        @(negedge clk);
        chk("abort_in_wait", {31'd0, obs_ready}, 32'd0);
        rst2 = 1'b1;
        #1;
        chk("abort_hreadyout", {31'd0, obs_ready}, 32'd1);
        chk("abort_hresp", {31'd0, obs_resp}, 32'd0);
        chk("abort_hrdata", obs_rdata, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst2 = 1'b0;
        @(posedge clk); #1;
        add_op("ws2_r8_post_abort", 1, 2'b10, 0, 3'b010, 32'h8, 32'h0, 32'h5555_AAAA, 0);
        run_ops(50);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ahb3lite_sram_slave.md
AHB3LITE_SRAM_SLAVE -- requirements
Module: ahb3lite_sram_slave

Interface
REQ-001 SHALL have parameter HADDR_SIZE, default 32, address bus width.
REQ-002 SHALL have parameter HDATA_SIZE, default 32, data bus width; only 32 is supported.
REQ-003 SHALL have parameter MEM_DEPTH, default 256, storage depth in 32-bit words.
REQ-004 SHALL have parameter WAIT_STATES, default 0, range 0..7, wait cycles inserted per OKAY transfer.
REQ-005 HCLK  input  1  single clock; all state updates on its rising edge.
REQ-006 HRESET  input  1  reset; asynchronous, active-high.
REQ-007 HSEL  input  1  slave select.
REQ-008 HADDR  input  HADDR_SIZE  byte address, address phase.
REQ-009 HWRITE  input  1  1 = write, 0 = read.
REQ-010 HSIZE  input  3  transfer size: 000 = byte, 001 = halfword, 010 = word.
REQ-011 HBURST, HPROT  input  3, 4  accepted; no functional effect.
REQ-012 HTRANS  input  2  00 = IDLE, 01 = BUSY, 10 = NONSEQ, 11 = SEQ.
REQ-013 HWDATA  input  HDATA_SIZE  write data, data phase.
REQ-014 HREADY  input  1  bus-level ready; an address phase completes only when this is 1.
REQ-015 HREADYOUT  output  1  slave ready.
REQ-016 HRESP  output  1  0 = OKAY, 1 = ERROR.
REQ-017 HRDATA  output  HDATA_SIZE  read data.

Function
REQ-018 Address phase accepted when HSEL=1, HREADY=1 and HTRANS[1]=1.
- On acceptance, register HADDR, HWRITE and HSIZE.
REQ-019 Selected IDLE/BUSY, or HSEL=0, SHALL give a zero-wait OKAY response (HREADYOUT=1, HRESP=0) and SHALL NOT access memory.
REQ-020 Accepted transfer is illegal if any of the following holds; illegal transfers take the ERROR path:
- HSIZE>010
- halfword with HADDR[0]=1
- word with HADDR[1:0]!=0
- HADDR>=MEM_DEPTH*4
REQ-021 FSM states:
- IDLE
- WAIT: counter loaded with WAIT_STATES; HREADYOUT=0, HRESP=0; decrements each cycle.
- LAST: HREADYOUT=1, HRESP=0.
- ERR1: HREADYOUT=0, HRESP=1.
- ERR2: HREADYOUT=1, HRESP=1.
REQ-022 Transitions:
- Legal accept -> WAIT if WAIT_STATES>0, else LAST.
- WAIT -> LAST when the counter reaches 0.
- Illegal accept -> ERR1 -> ERR2.
- LAST/ERR2 with a new accept -> per the rules above; otherwise -> IDLE.
REQ-023 Write commit:
- Memory write occurs on the HCLK edge ending LAST, using HWDATA sampled at that edge.
- Only the byte lanes selected by the registered HSIZE and HADDR[1:0] are written, little-endian.
- Unselected bytes are unchanged.
REQ-024 Read data:
- HRDATA = mem[registered HADDR word index] whenever the FSM is in LAST for a read; 32'h0 otherwise.
- The full word is driven regardless of HSIZE.
REQ-025 A back-to-back read to an address written in the immediately preceding transfer SHALL return the newly written data.
REQ-026 Transfers taking the ERROR path SHALL never modify memory.
REQ-027 With WAIT_STATES=0, legal transfers complete with zero wait states and can be pipelined every cycle.

Reset
REQ-028 While HRESET=1: FSM=IDLE, wait counter=0, HREADYOUT=1, HRESP=0, HRDATA=0, registered address-phase fields cleared.
REQ-029 Memory contents SHALL NOT be reset.
REQ-030 Reset asserted mid-transfer, in any state, SHALL abort the transfer with no memory write.

Verification
REQ-031 WAIT_STATES=0: word write 32'hCAFE_BABE @0x0, then word read @0x0 -> HRDATA=32'hCAFE_BABE, HRESP=0, no wait cycles. Repeat with 32'hDEAD_BEEF @0x4 -> read returns 32'hDEAD_BEEF; 0x0 still holds 32'hCAFE_BABE.
REQ-032 After REQ-031: byte write HWDATA=32'h0000_AA00 @0x1, then word read @0x0 -> 32'hCAFE_AABE. Halfword write 32'h1234_0000 @0x6 -> read @0x4 returns 32'h1234_BEEF.
REQ-033 Word write @0x2 with HWDATA=32'hFFFF_FFFF -> ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1); read @0x0 still returns 32'hCAFE_AABE. Write @MEM_DEPTH*4 -> same two-cycle ERROR.
REQ-034 WAIT_STATES=2: word write/read @0x8 -> HREADYOUT=0 for exactly 2 cycles per transfer; read returns the written value.
REQ-035 WAIT_STATES=2: assert HRESET during the write's WAIT state -> HREADYOUT=1, HRESP=0 immediately. After reset release, read @0x8 returns the value held before the aborted write.
